// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore control FSM for the multi-cycle MIPS datapath
// Control strobes are registered with the state; rst gates them to zero.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [3:0]       state,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    RDONE  = 4'd7,
    BRANCH = 4'd8,
    JUMP   = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
  } ctrl_t;

  state_t state_q;
  state_t state_nxt;
  ctrl_t  ctrl_q;
  logic   op_legal;
  logic   retire;

  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_write  = 1'b1;
      end
      DECODE: c.alu_src_b = 2'b11;
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      RDONE: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ADDIWB: c.reg_write = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

  assign retire = (state_q == MEMWB) || (state_q == MEMWR) || (state_q == RDONE) ||
                  (state_q == BRANCH) || (state_q == JUMP) || (state_q == ADDIWB);

  always_comb begin
    state_nxt = FETCH;
    case (state_q)
      FETCH: state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXEC;
          OP_BEQ:       state_nxt = BRANCH;
          OP_J:         state_nxt = JUMP;
          OP_ADDI:      state_nxt = ADDIEX;
          default:      state_nxt = FETCH;
        endcase
      end
      // IR is not reloaded after FETCH, so opcode is still the same instruction here.
      MEMADR: state_nxt = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXEC:   state_nxt = RDONE;
      ADDIEX: state_nxt = ADDIWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      ctrl_q     <= ctrl_of(FETCH);
      instrCount <= '0;
    end else begin
      state_q <= state_nxt;
      ctrl_q  <= ctrl_of(state_nxt);
      if (retire) begin
        instrCount <= instrCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Reset masks every strobe immediately, including mid-instruction aborts.
  assign {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
          PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst} = rst ? '0 : ctrl_q;

  assign state     = rst ? 4'd0 : state_q;
  assign illegalOp = !rst && (state_q == DECODE) && !op_legal;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the multi-cycle MIPS datapath. It sequences fetch, decode, execute, memory and write-back, and drives the datapath's register write enables, multiplexer selects and ALU operation class. It sits directly upstream of the datapath registers (IR, MDR, A, B, ALUOut, PC). It consumes the opcode held in the instruction register. It also keeps a retired-instruction counter and flags unsupported opcodes.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- clk  input  1  rising-edge clock shared with all datapath registers
- rst  input  1  synchronous, active-high reset
- opcode  input  6  instruction bits [31:26] from the instruction register output
- PCWrite  output  1  unconditional PC write enable
- PCWriteCond  output  1  PC write enable qualified by the ALU zero flag (in datapath)
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead  output  1  memory read strobe
- MemWrite  output  1  memory write strobe
- MemtoReg  output  1  register-file write data select: 0 = ALUOut, 1 = MDR
- IRWrite  output  1  instruction register load enable
- PCSource  output  2  PC next select: 00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  output  2  00 = add, 01 = sub, 10 = decode funct
- ALUSrcA  output  1  0 = PC, 1 = A
- ALUSrcB  output  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
- RegWrite  output  1  register-file write enable
- RegDst  output  1  destination select: 0 = rt, 1 = rd
- state  output  4  current state encoding, for debug
- illegalOp  output  1  one-cycle pulse when decode sees an unsupported opcode
- instrCount  output  CNT_W  count of retired legal instructions

## Operation
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. All others are illegal.
- States and their asserted outputs. Any output not listed is 0; any select not listed is 0/00.
- FETCH (0): MemRead, IRWrite, ALUSrcB=01, PCWrite. Always goes to DECODE.
- DECODE (1): ALUSrcB=11. Next state by opcode:
  - lw/sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - illegal → FETCH, with illegalOp=1 during DECODE
- MEMADR (2): ALUSrcA=1, ALUSrcB=10. lw → MEMRD; sw → MEMWR. The opcode is re-sampled here and is stable because IRWrite=0.
- MEMRD (3): MemRead, IorD. Goes to MEMWB.
- MEMWB (4): RegWrite, MemtoReg. Goes to FETCH.
- MEMWR (5): MemWrite, IorD. Goes to FETCH.
- EXEC (6): ALUSrcA=1, ALUOp=10. Goes to RDONE.
- RDONE (7): RegWrite, RegDst. Goes to FETCH.
- BRANCH (8): ALUSrcA=1, ALUOp=01, PCWriteCond, PCSource=01. Goes to FETCH.
- JUMP (9): PCWrite, PCSource=10. Goes to FETCH.
- ADDIEX (10): ALUSrcA=1, ALUSrcB=10. Goes to ADDIWB.
- ADDIWB (11): RegWrite. Goes to FETCH.
- Encodings 12–15 are unreachable. If entered, the FSM goes to FETCH on the next edge with all outputs 0.
- All control outputs decode from the state register only (Moore). No output depends combinationally on opcode, except illegalOp, which is DECODE AND illegal-opcode.
- instrCount increments by 1 on each edge that leaves MEMWB, MEMWR, RDONE, BRANCH, JUMP or ADDIWB. Illegal opcodes do not count. The counter wraps modulo 2^CNT_W.

## Timing
- Reset: sampled on the rising edge of clk.
  - While rst=1, every control output, illegalOp and state read 0. They are forced combinationally, so no memory or register strobes fire during reset.
  - On the edge where rst=1: state ← FETCH and instrCount ← 0.
  - The first cycle after rst falls is FETCH.
- Reset mid-instruction aborts the instruction. No further strobes fire, and the next instruction begins at FETCH.
- opcode must be valid from DECODE onward. The IR is loaded at the end of FETCH.
- Latency in cycles, FETCH through the last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- instrCount is updated in the cycle following the final state, i.e. it is visible during the next FETCH.

## Test plan
- Reset: hold rst for 3 cycles → all outputs 0, state=0 throughout. Release → FETCH with MemRead=IRWrite=PCWrite=1, ALUSrcB=01.
- lw (opcode 100011) → state sequence 0,1,2,3,4,0. RegWrite=MemtoReg=1 only in state 4. instrCount 0→1.
- sw, then R-type, then addi → sequences 0,1,2,5 / 0,1,6,7 / 0,1,10,11. MemWrite only in 5. RegDst=1 only in 7. instrCount reaches 3.
- beq, then j → 0,1,8 with PCWriteCond=1, PCSource=01, ALUOp=01; then 0,1,9 with PCWrite=1, PCSource=10.
- Illegal opcode 111111 → 0,1,0. illegalOp=1 for exactly one cycle. instrCount unchanged. No RegWrite/MemWrite.
- Assert rst during MEMRD of a lw → MemRead drops in the same cycle, no MEMWB occurs, state=FETCH after release, instrCount=0. Preload instrCount to all-ones and retire a j → it wraps to 0.
